// File: rtl/sick_encoder.sv
// sick_encoder
//   Streaming instruction encoder for the Sick stack ISA. Converts
//   (kind, value) requests into 16-bit instruction words, inserting a Pre
//   prefix word when the operand's top nibble cannot be implied, and tags
//   every emitted word with its instruction-memory address.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   org_load   in   load address counter from org_addr (IDLE only)
//   org_addr   in   [15:0] new emission address
//   in_valid   in   request present
//   in_ready   out  request accepted on in_valid && in_ready
//   in_kind    in   [3:0] request kind
//   in_value   in   [15:0] operand (subop in [3:0] for kind 0)
//   out_valid  out  out_word valid
//   out_ready  in   consumer takes word on out_valid && out_ready
//   out_word   out  [15:0] encoded instruction word
//   out_addr   out  [15:0] memory address of out_word
//   err        out  sticky illegal-request flag
module sick_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        org_load,
  input  logic [15:0] org_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [15:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [15:0] out_addr,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT_PRE = 2'd1,
    EMIT_OP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] word_q, word_d;
  logic [15:0] op_q, op_d;
  logic        err_q, err_d;

  logic [15:0] base_addr;
  logic [15:0] exec_pc;

  function automatic logic is_legal(input logic [3:0] kind, input logic [15:0] value);
    logic ok;
    ok = 1'b0;
    case (kind)
      4'h0:                      ok = (value[15:4] == 12'h000) && (value[3:0] <= 4'hb);
      4'h1, 4'h4, 4'h5,
      4'h6, 4'h7:                ok = 1'b1;
      4'h8, 4'h9, 4'ha:          ok = (value[15:8] == 8'h00);
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Push sign-extends from bit 11; control transfers inherit the top nibble
  // of the pc the processor holds when the instruction executes.
  function automatic logic needs_pre(input logic [3:0] kind, input logic [15:0] value,
                                     input logic [15:0] pc);
    logic pre;
    pre = 1'b0;
    case (kind)
      4'h1:                      pre = (value[15:12] != {4{value[11]}});
      4'h4, 4'h5, 4'h6, 4'h7:    pre = (value[15:12] != pc[15:12]);
      default:                   pre = 1'b0;
    endcase
    return pre;
  endfunction

  function automatic logic [15:0] enc_op(input logic [3:0] kind, input logic [15:0] value);
    logic [15:0] w;
    case (kind)
      4'h8, 4'h9, 4'ha:          w = {kind, 4'h0, value[7:0]};
      4'h0:                      w = {12'h000, value[3:0]};
      default:                   w = {kind, value[11:0]};
    endcase
    return w;
  endfunction

  assign base_addr = org_load ? org_addr : addr_q;
  assign exec_pc   = base_addr + 16'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (org_load) addr_d = org_addr;
        if (in_valid) begin
          if (!is_legal(in_kind, in_value)) begin
            // Illegal requests are swallowed; only the sticky flag records them.
            err_d = 1'b1;
          end else begin
            op_d = enc_op(in_kind, in_value);
            if (needs_pre(in_kind, in_value, exec_pc)) begin
              word_d  = {4'hb, 8'h00, in_value[15:12]};
              state_d = EMIT_PRE;
            end else begin
              word_d  = enc_op(in_kind, in_value);
              state_d = EMIT_OP;
            end
          end
        end
      end
      EMIT_PRE: begin
        if (out_ready) begin
          addr_d  = addr_q + 16'd1;
          word_d  = op_q;
          state_d = EMIT_OP;
        end
      end
      EMIT_OP: begin
        if (out_ready) begin
          addr_d  = addr_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      word_q  <= 16'h0000;
      op_q    <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode straight from state so an asynchronous reset
  // drops them in the same cycle it is asserted.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q != IDLE);
  assign out_word  = word_q;
  assign out_addr  = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sick_encoder.sv
module tb_sick_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        org_load;
  logic [15:0] org_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [15:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [15:0] out_addr;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_addr;
  logic        m_err;

  always #5 clk = ~clk;

  sick_encoder dut (
    .clk(clk), .reset(reset), .org_load(org_load), .org_addr(org_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: list of words the ISA requires for a request issued at address a.
  task automatic model(input logic [3:0] k, input logic [15:0] v, input logic [15:0] a,
                       output logic legal, output logic [15:0] words[$]);
    int unsigned val, pc, opnd;
    logic [15:0] pre;
    val = v;
    pc  = (a + 1) % 65536;
    pre = 16'hb000 + 16'(val / 4096);
    words = {};
    legal = 1'b0;
    if (k == 0) begin
      legal = (val <= 11);
      if (legal) words.push_back(16'(val));
    end else if (k == 1) begin
      legal = 1'b1;
      // Fits without prefix iff the value is a 12-bit signed number.
      if (!(val < 2048 || val >= 65536 - 2048)) words.push_back(pre);
      words.push_back(16'(4096 + val % 4096));
    end else if (k >= 4 && k <= 7) begin
      legal = 1'b1;
      if (val / 4096 != pc / 4096) words.push_back(pre);
      words.push_back(16'(k * 4096 + val % 4096));
    end else if (k >= 8 && k <= 10) begin
      legal = (val <= 255);
      opnd = k * 4096 + val;
      if (legal) words.push_back(16'(opnd));
    end
  endtask

  // Issue one request and follow it to completion. stall >= 0 holds
  // out_ready low for that many cycles on the first word; stall < 0 randomizes.
  task automatic do_req(input logic [3:0] k, input logic [15:0] v, input logic ol,
                        input logic [15:0] oa, input int stall);
    logic        legal, rdy;
    logic [15:0] words[$];
    int          n;
    in_valid = 1'b1; in_kind = k; in_value = v; org_load = ol; org_addr = oa;
    out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; org_load = 1'b0;
    if (ol) m_addr = oa;
    model(k, v, m_addr, legal, words);
    if (!legal) begin
      m_err = 1'b1;
      @(negedge clk);
      check("illegal_no_out", out_valid, 0);
      check("err_set", err, 1);
      check("illegal_in_ready", in_ready, 1);
      @(posedge clk); #1;
      return;
    end
    foreach (words[i]) begin
      n = 0;
      do begin
        if (stall >= 0) rdy = (i > 0) || (n >= stall);
        else            rdy = (n >= 4) || ($urandom_range(0, 2) != 0);
        out_ready = rdy;
        @(negedge clk);
        check("out_valid", out_valid, 1);
        check("out_word", out_word, words[i]);
        check("out_addr", out_addr, m_addr);
        check("in_ready_busy", in_ready, 0);
        @(posedge clk); #1;
        n++;
      end while (!rdy);
      m_addr = m_addr + 16'd1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("done_valid", out_valid, 0);
    check("done_in_ready", in_ready, 1);
    check("done_addr", out_addr, m_addr);
    check("err_level", err, m_err);
    @(posedge clk); #1;
  endtask

  task automatic org_only(input logic [15:0] oa);
    org_load = 1'b1; org_addr = oa;
    @(posedge clk); #1;
    org_load = 1'b0;
    m_addr = oa;
    @(negedge clk);
    check("org_only_addr", out_addr, oa);
    check("org_only_valid", out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_emission();
    in_valid = 1'b1; in_kind = 4'h1; in_value = 16'h1234; out_ready = 1'b0;
    org_load = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pending_word", out_word, 16'hb001);
    check("rst_pending_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_ready", in_ready, 0);
    check("rst_async_addr", out_addr, 0);
    check("rst_async_word", out_word, 0);
    check("rst_async_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_addr = 16'h0000;
    m_err  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  legal_kinds[9];
    logic [3:0]  bad_kinds[7];
    logic [3:0]  k;
    logic [15:0] v, oa;
    logic        ol;
    legal_kinds = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha};
    bad_kinds   = '{4'h2, 4'h3, 4'hb, 4'hc, 4'hd, 4'he, 4'hf};

    reset = 1'b1; org_load = 1'b0; org_addr = 16'h0; in_valid = 1'b0;
    in_kind = 4'h0; in_value = 16'h0; out_ready = 1'b0;
    m_addr = 16'h0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_word", out_word, 0);
    check("reset_out_addr", out_addr, 0);
    check("reset_err", err, 0);
    check("reset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_req(4'h1, 16'h0005, 1'b1, 16'h0000, 0);
    do_req(4'h1, 16'hf800, 1'b0, 16'h0000, 0);
    do_req(4'h1, 16'h1234, 1'b1, 16'h0000, 0);
    do_req(4'h1, 16'h0800, 1'b0, 16'h0000, 0);
    do_req(4'h5, 16'h1003, 1'b1, 16'h0fff, 0);
    do_req(4'h5, 16'h1003, 1'b1, 16'h0ffe, 0);
    do_req(4'h0, 16'h000a, 1'b1, 16'hffff, 0);
    do_req(4'h1, 16'h1234, 1'b0, 16'h0000, 3);
    do_req(4'h8, 16'h0100, 1'b0, 16'h0000, 0);
    do_req(4'h2, 16'h0000, 1'b0, 16'h0000, 0);
    do_req(4'ha, 16'h0003, 1'b0, 16'h0000, 0);
    do_req(4'h0, 16'h000c, 1'b0, 16'h0000, 0);
    do_req(4'h0, 16'h0013, 1'b0, 16'h0000, 0);
    reset_mid_emission();
    do_req(4'h1, 16'h0005, 1'b0, 16'h0000, 0);
    org_only(16'h7ffe);
    do_req(4'h4, 16'h8001, 1'b0, 16'h0000, 1);

    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 9) < 8) k = legal_kinds[$urandom_range(0, 8)];
      else                          k = bad_kinds[$urandom_range(0, 6)];
      case ($urandom_range(0, 3))
        0: v = 16'($urandom);
        1: v = 16'($urandom_range(0, 15));
        2: v = 16'($urandom_range(0, 511));
        default: v = {m_addr[15:12], 12'($urandom)};
      endcase
      ol = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: oa = 16'($urandom);
        1: oa = {4'($urandom), 12'hffe};
        default: oa = 16'hffff;
      endcase
      do_req(k, v, ol, oa, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sick_encoder.md
# sick_encoder

Streaming instruction encoder for the Sick stack ISA. It turns (kind, value) requests into the 16-bit instruction words that the processor fetches and decodes, inserting a Pre prefix word whenever the operand's top nibble cannot be implied. It tracks the memory address of every emitted word, so jump and call prefixes are decided against the processor's post-increment pc. It sits between a program generator or loader and the instruction memory write port.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `org_load` in 1: load address counter from `org_addr`; honored only in IDLE.
- `org_addr` in 16: new emission address.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_kind` in 4: request kind. 0 = zero-operand op, 1 = push, 4 = call, 5 = jump, 6 = jumpf, 7 = jumpt, 8 = get, 9 = put, a = pop. All other values are illegal.
- `in_value` in 16: operand. For kind 0 it is the subop in [3:0].
- `out_valid` out 1: `out_word` valid.
- `out_ready` in 1: consumer takes the word when `out_valid && out_ready`.
- `out_word` out 16: encoded instruction word.
- `out_addr` out 16: memory address of `out_word`.
- `err` out 1: sticky illegal-request flag.

## Operation
States:
- IDLE: `in_ready`=1.
- EMIT_PRE
- EMIT_OP
- On accept: go to EMIT_PRE if a prefix is needed, else EMIT_OP. An illegal request stays in IDLE and sets `err`.

Prefix decision, evaluated at accept time with A = address counter (or `org_addr` if `org_load` is asserted in the same cycle):
- push: prefix iff value[15:12] != {4{value[11]}}.
- call/jump/jumpf/jumpt: prefix iff value[15:12] != (A+1)[15:12], where A+1 is the processor pc at execute time.
- all others: never.

Encodings:
- Pre word: {4'hb, 8'h00, value[15:12]}.
- push/call/jump/jumpf/jumpt: {kind, value[11:0]}.
- get/put/pop: {kind, 4'h0, value[7:0]}. Illegal if value > 16'h00ff.
- kind 0: {12'h000, value[3:0]}. Illegal if value[3:0] > 4'hb or value[15:4] != 0.

Address counter:
- Increments by 1 on each output handshake, modulo 2^16 (16'hffff wraps to 16'h0000).
- `out_addr` equals the counter.
- `org_load` outside IDLE is ignored.

Error flag: `err` is set on any illegal request and is cleared only by reset. An illegal request is consumed and produces no output.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_word`=0, `out_addr`=0, `err`=0. `in_ready`=0 while `reset` is high.
- Accept in cycle N; `out_valid`=1 from cycle N+1.
- `out_word` and `out_addr` are held stable while `out_valid && !out_ready`.
- `in_ready`=0 in EMIT_PRE and EMIT_OP.
- A handshake of the Pre word moves to EMIT_OP with the next word valid in the following cycle.
- A handshake of the op word returns to IDLE; `in_ready`=1 in the following cycle.
- Throughput: one 1-word instruction per 2 cycles; 3 cycles with a prefix.
- `err` rises the cycle after the illegal accept.
- Reset asserted mid-emission aborts immediately: no partial Pre/op completion, counter returns to 0.
- `org_load` with no request: counter = `org_addr` next cycle.

## Test plan
- Org 0, push 16'h0005 -> one word 16'h1005 at addr 0. Then push 16'hf800 -> 16'h1800 at addr 1, no prefix.
- Org 0, push 16'h1234 -> 16'hb001 at addr 0, then 16'h1234 at addr 1. Push 16'h0800 -> 16'hb000, then 16'h1800.
- Org 16'h0fff, jump 16'h1003 -> single 16'h5003 at 16'h0fff. Org 16'h0ffe, same jump -> 16'hb001 at 16'h0ffe, 16'h5003 at 16'h0fff. Org 16'hffff, kind 0 subop 4'ha -> 16'h000a at 16'hffff, next addr 16'h0000.
- Request push 16'h1234 with `out_ready` low for 3 cycles -> 16'hb001 and addr stable throughout, `in_ready`=0; completes after `out_ready` rises.
- Get 16'h0100 -> no output, `err`=1 next cycle. Kind 2 -> no output, `err` stays 1. Following pop 16'h0003 -> 16'ha003.
- Assert reset while 16'hb001 is pending -> `out_valid`=0 immediately; after release, push 16'h0005 -> 16'h1005 at addr 0.
